// File: rtl/prbs7_checker_pkg.sv
// prbs7_checker_pkg
//   Shared definitions for the PRBS7 checker:
//   - state_e          : checker state encoding (SEED / VERIFY / LOCKED)
//   - PRBS_LEN, TAP_*  : x^7 + x^6 + 1 register length and feedback taps
//   - DEF_*            : default values of the checker parameters
//   - ERR_COUNT_W      : width of the saturating error counter
//   - prbs7_predict()  : next expected bit from the current register state
package prbs7_checker_pkg;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int PRBS_LEN = 7;
   // Register bit indices feeding the XOR (x^7 and x^6 terms).
   localparam int TAP_A = 6;
   localparam int TAP_B = 5;

   localparam int DEF_LOCK_MATCHES = 16;
   localparam int DEF_LOSS_WINDOW  = 64;
   localparam int DEF_LOSS_ERRORS  = 8;

   localparam int ERR_COUNT_W = 16;

   function automatic logic prbs7_predict(input logic [PRBS_LEN-1:0] s);
      return s[TAP_A] ^ s[TAP_B];
   endfunction

endpackage

// File: rtl/prbs7_checker_if.sv
// prbs7_checker_if
//   Bundles the checker's data/status signals.
//   Driven by the source side (master):
//     CLK_SLOW   - divided bit clock, asynchronous to CLK
//     DIN        - serial PRBS7 data, launched on CLK_SLOW rising edge
//     CLR_CNT    - level clear of ERR_COUNT
//   Driven by the checker (slave):
//     LOCKED     - checker is in the LOCKED state
//     ERR        - one-CLK pulse per mismatched bit while locked
//     ERR_COUNT  - saturating mismatch count
//     SAMPLE_STB - one-CLK pulse per received bit
import prbs7_checker_pkg::*;

interface prbs7_checker_if;
   logic                   CLK_SLOW;
   logic                   DIN;
   logic                   CLR_CNT;
   logic                   LOCKED;
   logic                   ERR;
   logic [ERR_COUNT_W-1:0] ERR_COUNT;
   logic                   SAMPLE_STB;

   modport master (
      output CLK_SLOW,
      output DIN,
      output CLR_CNT,
      input  LOCKED,
      input  ERR,
      input  ERR_COUNT,
      input  SAMPLE_STB
   );

   modport slave (
      input  CLK_SLOW,
      input  DIN,
      input  CLR_CNT,
      output LOCKED,
      output ERR,
      output ERR_COUNT,
      output SAMPLE_STB
   );
endinterface

// File: rtl/prbs7_checker_slow_clk_sync.sv
// slow_clk_sync
//   Brings the slow bit clock and its data into the CLK domain.
//   Ports:
//     CLK      - system clock
//     RST      - asynchronous active-high reset
//     CLK_SLOW - raw slow bit clock (async)
//     DIN      - raw serial data (async)
//     strobe   - one-CLK pulse per CLK_SLOW rising edge, 3 CLK after the pin edge
//     rx_bit   - synchronized DIN captured alongside strobe
module slow_clk_sync (
   input  logic CLK,
   input  logic RST,
   input  logic CLK_SLOW,
   input  logic DIN,
   output logic strobe,
   output logic rx_bit
);

   logic       clk_slow_meta_q, clk_slow_meta_d;
   logic       clk_slow_sync_q, clk_slow_sync_d;
   logic       clk_slow_prev_q, clk_slow_prev_d;
   logic       din_meta_q,      din_meta_d;
   logic       din_sync_q,      din_sync_d;
   logic [1:0] arm_cnt_q,       arm_cnt_d;
   logic       strobe_q,        strobe_d;
   logic       rx_bit_q,        rx_bit_d;

   always_comb begin
      clk_slow_meta_d = CLK_SLOW;
      clk_slow_sync_d = clk_slow_meta_q;
      clk_slow_prev_d = clk_slow_sync_q;
      din_meta_d      = DIN;
      din_sync_d      = din_meta_q;
      rx_bit_d        = din_sync_q;
      arm_cnt_d       = arm_cnt_q;
      if (arm_cnt_q != 2'd3) begin
         arm_cnt_d = arm_cnt_q + 2'd1;
      end
      // Edge detection stays disarmed until the previous-value flop holds a
      // real sample; otherwise a CLK_SLOW already high when reset releases
      // would look like a 0->1 transition against the reset value.
      strobe_d = (arm_cnt_q == 2'd3) && clk_slow_sync_q && !clk_slow_prev_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         clk_slow_meta_q <= 1'b0;
         clk_slow_sync_q <= 1'b0;
         clk_slow_prev_q <= 1'b0;
         din_meta_q      <= 1'b0;
         din_sync_q      <= 1'b0;
         arm_cnt_q       <= 2'd0;
         strobe_q        <= 1'b0;
         rx_bit_q        <= 1'b0;
      end else begin
         clk_slow_meta_q <= clk_slow_meta_d;
         clk_slow_sync_q <= clk_slow_sync_d;
         clk_slow_prev_q <= clk_slow_prev_d;
         din_meta_q      <= din_meta_d;
         din_sync_q      <= din_sync_d;
         arm_cnt_q       <= arm_cnt_d;
         strobe_q        <= strobe_d;
         rx_bit_q        <= rx_bit_d;
      end
   end

   assign strobe = strobe_q;
   assign rx_bit = rx_bit_q;

endmodule

// File: rtl/prbs7_checker.sv
// prbs7_checker
//   Receives a slow-clocked PRBS7 (x^7+x^6+1) stream, seeds a local
//   generator from the data, verifies it, then tracks bit errors while locked.
//   Loss of lock occurs when LOSS_ERRORS errors fall inside one
//   LOSS_WINDOW-bit window.
//   Ports:
//     CLK  - system clock, all state on its rising edge
//     RST  - asynchronous active-high reset
//     bus  - prbs7_checker_if.slave (CLK_SLOW, DIN, CLR_CNT in;
//            LOCKED, ERR, ERR_COUNT, SAMPLE_STB out)
import prbs7_checker_pkg::*;

module prbs7_checker #(
   parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
   parameter int LOSS_WINDOW  = DEF_LOSS_WINDOW,
   parameter int LOSS_ERRORS  = DEF_LOSS_ERRORS
) (
   input  logic            CLK,
   input  logic            RST,
   prbs7_checker_if.slave  bus
);

   localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
   localparam int WIN_W   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
   localparam int LERR_W  = $clog2(LOSS_ERRORS + 1);

   localparam logic [MATCH_W-1:0] LOCK_MATCHES_C = MATCH_W'(LOCK_MATCHES);
   localparam logic [WIN_W-1:0]   WIN_LAST_C     = WIN_W'(LOSS_WINDOW - 1);
   localparam logic [LERR_W-1:0]  LOSS_ERRORS_C  = LERR_W'(LOSS_ERRORS);

   logic strobe;
   logic rx_bit;

   slow_clk_sync u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .CLK_SLOW (bus.CLK_SLOW),
      .DIN      (bus.DIN),
      .strobe   (strobe),
      .rx_bit   (rx_bit)
   );

   state_e                 state_q,      state_d;
   logic [PRBS_LEN-1:0]    s_q,          s_d;
   logic [2:0]             seed_cnt_q,   seed_cnt_d;
   logic [MATCH_W-1:0]     match_cnt_q,  match_cnt_d;
   logic [WIN_W-1:0]       win_bit_q,    win_bit_d;
   logic [LERR_W-1:0]      win_err_q,    win_err_d;
   logic [ERR_COUNT_W-1:0] err_count_q,  err_count_d;
   logic                   err_q,        err_d;
   logic                   sample_stb_q, sample_stb_d;

   logic                   predicted;
   logic                   mismatch;
   logic [PRBS_LEN-1:0]    s_self;
   logic [PRBS_LEN-1:0]    s_shift;
   logic [LERR_W-1:0]      win_err_sum;
   logic                   err_inc;

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      seed_cnt_d   = seed_cnt_q;
      match_cnt_d  = match_cnt_q;
      win_bit_d    = win_bit_q;
      win_err_d    = win_err_q;
      err_d        = 1'b0;
      sample_stb_d = strobe;
      err_inc      = 1'b0;

      predicted    = prbs7_predict(s_q);
      mismatch     = rx_bit ^ predicted;
      s_self       = {s_q[PRBS_LEN-2:0], predicted};
      s_shift      = {s_q[PRBS_LEN-2:0], rx_bit};
      win_err_sum  = win_err_q + LERR_W'(mismatch);

      if (strobe) begin
         case (state_q)
            ST_SEED: begin
               s_d = s_shift;
               if (seed_cnt_q != 3'd7) begin
                  seed_cnt_d = seed_cnt_q + 3'd1;
               end
               // seed_cnt_q >= 6 means this bit completes (or extends past)
               // the 7-bit fill; an all-zero register can never run, so keep
               // shifting until a non-zero state appears.
               if ((seed_cnt_q >= 3'd6) && (s_shift != '0)) begin
                  state_d     = ST_VERIFY;
                  match_cnt_d = '0;
               end
            end

            ST_VERIFY: begin
               s_d = s_self;
               if (!mismatch) begin
                  match_cnt_d = match_cnt_q + 1'b1;
                  if ((match_cnt_q + 1'b1) == LOCK_MATCHES_C) begin
                     state_d     = ST_LOCKED;
                     match_cnt_d = '0;
                     win_bit_d   = '0;
                     win_err_d   = '0;
                  end
               end else begin
                  state_d     = ST_SEED;
                  seed_cnt_d  = 3'd0;
                  match_cnt_d = '0;
               end
            end

            ST_LOCKED: begin
               // Free-running: the local generator is never reloaded from rx,
               // so line errors cannot corrupt the reference.
               s_d = s_self;
               if (mismatch) begin
                  err_d   = 1'b1;
                  err_inc = 1'b1;
               end
               if (win_err_sum == LOSS_ERRORS_C) begin
                  state_d    = ST_SEED;
                  seed_cnt_d = 3'd0;
                  win_bit_d  = '0;
                  win_err_d  = '0;
               end else if (win_bit_q == WIN_LAST_C) begin
                  win_bit_d = '0;
                  win_err_d = '0;
               end else begin
                  win_bit_d = win_bit_q + 1'b1;
                  win_err_d = win_err_sum;
               end
            end

            default: begin
               state_d    = ST_SEED;
               seed_cnt_d = 3'd0;
            end
         endcase
      end

      // Clear wins over a same-cycle increment; count saturates.
      err_count_d = err_count_q;
      if (bus.CLR_CNT) begin
         err_count_d = '0;
      end else if (err_inc && (err_count_q != '1)) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_SEED;
         s_q          <= '0;
         seed_cnt_q   <= 3'd0;
         match_cnt_q  <= '0;
         win_bit_q    <= '0;
         win_err_q    <= '0;
         err_count_q  <= '0;
         err_q        <= 1'b0;
         sample_stb_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         seed_cnt_q   <= seed_cnt_d;
         match_cnt_q  <= match_cnt_d;
         win_bit_q    <= win_bit_d;
         win_err_q    <= win_err_d;
         err_count_q  <= err_count_d;
         err_q        <= err_d;
         sample_stb_q <= sample_stb_d;
      end
   end

   assign bus.LOCKED     = (state_q == ST_LOCKED);
   assign bus.ERR        = err_q;
   assign bus.ERR_COUNT  = err_count_q;
   assign bus.SAMPLE_STB = sample_stb_q;

endmodule

// File: tb/tb_prbs7_checker.sv
import prbs7_checker_pkg::*;

module tb_prbs7_checker;

   logic CLK;
   logic RST;

   prbs7_checker_if bus ();

   prbs7_checker #(
      .LOCK_MATCHES (16),
      .LOSS_WINDOW  (64),
      .LOSS_ERRORS  (8)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Reference PRBS7 generator (x^7+x^6+1), and window position since lock.
   logic [6:0] gen_s;
   int         bits_since_lock = 0;

   // Observations of the last bit sent.
   logic        obs_stb_early, obs_stb, obs_stb_late;
   logic        obs_err, obs_err_late, obs_locked;
   logic [15:0] obs_cnt;

   int stb_total = 0;
   int err_total = 0;
   always @(negedge CLK) begin
      if (bus.SAMPLE_STB === 1'b1) stb_total++;
      if (bus.ERR === 1'b1) err_total++;
   end

   task automatic gen_bit(output logic b);
      b = gen_s[6] ^ gen_s[5];
      gen_s = {gen_s[5:0], b};
   endtask

   // One slow-clock bit: pin edge, then sample 3/4/5 CLK later.
   task automatic send_bit(input logic b);
      @(posedge CLK); #1;
      bus.DIN = b;
      bus.CLK_SLOW = 1'b1;
      repeat (3) @(posedge CLK);
      #1 obs_stb_early = bus.SAMPLE_STB;
      @(posedge CLK);
      #1;
      obs_stb    = bus.SAMPLE_STB;
      obs_err    = bus.ERR;
      obs_locked = bus.LOCKED;
      obs_cnt    = bus.ERR_COUNT;
      @(posedge CLK);
      #1;
      obs_stb_late = bus.SAMPLE_STB;
      obs_err_late = bus.ERR;
      repeat (2) @(posedge CLK);
      #1 bus.CLK_SLOW = 1'b0;
      repeat (4) @(posedge CLK);
      bits_since_lock++;
   endtask

   task automatic send_gen(input logic flip);
      logic b;
      gen_bit(b);
      send_bit(b ^ flip);
   endtask

   task automatic pad_to_window();
      while ((bits_since_lock % 64) != 0) begin
         send_gen(1'b0);
         checks++;
         if (obs_err !== 1'b0 || obs_locked !== 1'b1) begin
            errors++;
            $display("FAIL pad_bit: err=%b locked=%b expected err=0 locked=1", obs_err, obs_locked);
         end
      end
   endtask

   // Clean stream from wherever gen_s is; LOCKED must rise exactly on bit 23.
   task automatic relock_check(input string tag, input logic [15:0] exp_cnt);
      for (int i = 1; i <= 23; i++) begin
         send_gen(1'b0);
         checks++;
         if (obs_locked !== (i >= 23) || obs_err !== 1'b0 || obs_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s bit %0d: locked=%b err=%b cnt=%0d expected locked=%b err=0 cnt=%0d",
                     tag, i, obs_locked, obs_err, obs_cnt, (i >= 23), exp_cnt);
         end
      end
      bits_since_lock = 0;
   endtask

   task automatic test_reset();
      int stb_before;
      RST = 1'b1;
      bus.CLK_SLOW = 1'b1;
      bus.DIN = 1'b1;
      bus.CLR_CNT = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (bus.LOCKED !== 1'b0 || bus.ERR !== 1'b0 || bus.ERR_COUNT !== 16'd0 || bus.SAMPLE_STB !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: locked=%b err=%b cnt=%0d stb=%b expected all 0",
                  bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.SAMPLE_STB);
      end
      stb_before = stb_total;
      RST = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      checks++;
      if (stb_total !== stb_before) begin
         errors++;
         $display("FAIL reset_high_clk_slow: strobes=%0d expected 0", stb_total - stb_before);
      end
      bus.CLK_SLOW = 1'b0;
      repeat (5) @(posedge CLK);
   endtask

   task automatic test_clean_lock();
      gen_s = 7'h7F;
      for (int i = 1; i <= 30; i++) begin
         send_gen(1'b0);
         if (i == 1) begin
            checks++;
            if (obs_stb_early !== 1'b0 || obs_stb !== 1'b1 || obs_stb_late !== 1'b0) begin
               errors++;
               $display("FAIL strobe_latency: edge3=%b edge4=%b edge5=%b expected 0 1 0",
                        obs_stb_early, obs_stb, obs_stb_late);
            end
         end
         checks++;
         if (obs_locked !== (i >= 23) || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL clean_lock bit %0d: locked=%b err=%b expected locked=%b err=0",
                     i, obs_locked, obs_err, (i >= 23));
         end
         if (i == 23) bits_since_lock = 0;
      end
      checks++;
      if (obs_cnt !== 16'd0) begin
         errors++;
         $display("FAIL clean_lock_count: cnt=%0d expected 0", obs_cnt);
      end
   endtask

   task automatic test_loss_of_lock();
      int k;
      pad_to_window();
      k = 0;
      for (int j = 0; j <= 14; j++) begin
         if (j % 2 == 0) begin
            k++;
            send_gen(1'b1);
            checks++;
            if (obs_err !== 1'b1 || obs_cnt !== k[15:0] || obs_locked !== (k < 8)) begin
               errors++;
               $display("FAIL loss_flip %0d: err=%b cnt=%0d locked=%b expected err=1 cnt=%0d locked=%b",
                        k, obs_err, obs_cnt, obs_locked, k, (k < 8));
            end
         end else begin
            send_gen(1'b0);
            checks++;
            if (obs_err !== 1'b0 || obs_locked !== 1'b1) begin
               errors++;
               $display("FAIL loss_clean %0d: err=%b locked=%b expected err=0 locked=1", j, obs_err, obs_locked);
            end
         end
      end
      relock_check("relock_after_loss", 16'd8);
   endtask

   task automatic test_clr_and_single_flip();
      bus.CLR_CNT = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (bus.ERR_COUNT !== 16'd0) begin
         errors++;
         $display("FAIL clr_cnt: cnt=%0d expected 0", bus.ERR_COUNT);
      end
      bus.CLR_CNT = 1'b0;

      send_gen(1'b1);
      checks++;
      if (obs_err !== 1'b1 || obs_err_late !== 1'b0 || obs_cnt !== 16'd1 || obs_locked !== 1'b1) begin
         errors++;
         $display("FAIL single_flip: err=%b err_next=%b cnt=%0d locked=%b expected 1 0 1 1",
                  obs_err, obs_err_late, obs_cnt, obs_locked);
      end
      for (int i = 0; i < 10; i++) begin
         send_gen(1'b0);
         checks++;
         if (obs_err !== 1'b0 || obs_cnt !== 16'd1 || obs_locked !== 1'b1) begin
            errors++;
            $display("FAIL after_flip %0d: err=%b cnt=%0d locked=%b expected 0 1 1", i, obs_err, obs_cnt, obs_locked);
         end
      end

      pad_to_window();
      for (int i = 0; i < 4; i++) begin
         send_gen(1'b1);
         send_gen(1'b0);
      end
      checks++;
      if (obs_cnt !== 16'd5 || obs_locked !== 1'b1) begin
         errors++;
         $display("FAIL count_to_5: cnt=%0d locked=%b expected cnt=5 locked=1", obs_cnt, obs_locked);
      end

      bus.CLR_CNT = 1'b1;
      send_gen(1'b1);
      bus.CLR_CNT = 1'b0;
      checks++;
      if (obs_err !== 1'b1 || obs_cnt !== 16'd0 || obs_locked !== 1'b1) begin
         errors++;
         $display("FAIL clr_on_error: err=%b cnt=%0d locked=%b expected err=1 cnt=0 locked=1",
                  obs_err, obs_cnt, obs_locked);
      end
   endtask

   task automatic test_stuck_clock();
      int stb_before;
      int err_before;
      stb_before = stb_total;
      err_before = err_total;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1 bus.DIN = ~bus.DIN;
      end
      repeat (5) @(posedge CLK);
      #1;
      checks++;
      if (stb_total !== stb_before || err_total !== err_before || bus.LOCKED !== 1'b1 || bus.ERR_COUNT !== 16'd0) begin
         errors++;
         $display("FAIL stuck_clk_slow: strobes=%0d errs=%0d locked=%b cnt=%0d expected 0 0 1 0",
                  stb_total - stb_before, err_total - err_before, bus.LOCKED, bus.ERR_COUNT);
      end
   endtask

   task automatic test_reset_mid();
      pad_to_window();
      for (int i = 0; i < 3; i++) begin
         send_gen(1'b1);
         send_gen(1'b0);
      end
      checks++;
      if (obs_cnt !== 16'd3 || obs_locked !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: cnt=%0d locked=%b expected cnt=3 locked=1", obs_cnt, obs_locked);
      end
      @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      checks++;
      if (bus.LOCKED !== 1'b0 || bus.ERR !== 1'b0 || bus.ERR_COUNT !== 16'd0 || bus.SAMPLE_STB !== 1'b0) begin
         errors++;
         $display("FAIL reset_immediate: locked=%b err=%b cnt=%0d stb=%b expected all 0",
                  bus.LOCKED, bus.ERR, bus.ERR_COUNT, bus.SAMPLE_STB);
      end
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (5) @(posedge CLK);
      gen_s = 7'h7F;
      relock_check("relock_after_reset", 16'd0);
   endtask

   task automatic test_din_zero();
      logic ever_locked;
      @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (5) @(posedge CLK);
      ever_locked = 1'b0;
      for (int i = 0; i < 200; i++) begin
         send_bit(1'b0);
         if (obs_locked !== 1'b0 || obs_err !== 1'b0) ever_locked = 1'b1;
      end
      checks++;
      if (ever_locked !== 1'b0) begin
         errors++;
         $display("FAIL din_zero_locked: saw locked/err=%b expected 0", ever_locked);
      end
      checks++;
      if (dut.state_q !== ST_SEED) begin
         errors++;
         $display("FAIL din_zero_state: state=%0d expected %0d", dut.state_q, ST_SEED);
      end
   endtask

   initial begin
      RST = 1'b1;
      bus.CLK_SLOW = 1'b0;
      bus.DIN = 1'b0;
      bus.CLR_CNT = 1'b0;
      gen_s = 7'h7F;
      test_reset();
      test_clean_lock();
      test_loss_of_lock();
      test_clr_and_single_flip();
      test_stuck_clock();
      test_reset_mid();
      test_din_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
